uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 24 ++
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/rx_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: shared definitions for the UART receiver and its FIFO.
//   DATA_W        - serial data width (one byte)
//   rx_state_e    - receiver FSM states; PARITY exists only when
//                   UART_RX_PARITY_EN is defined (8E1 frames)
//   clks_per_bit  - system clocks per serial bit (integer division)
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial input, FIFO read handshake and sticky error flags.
//   rxd        - serial line, idle high
//   rd_ready   - consumer pops the head when rd_valid is also high
//   rd_data    - FIFO head byte (0 when empty)
//   rd_valid   - FIFO not empty
//   clr_err    - one-cycle pulse clearing the sticky flags
//   frame_err / overrun / parity_err - sticky error flags
// master: the consumer side; slave: the receiver.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic              rxd;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clr_err;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  modport master (
    output rxd, rd_ready, clr_err,
    input  rd_data, rd_valid, frame_err, overrun, parity_err
  );

  modport slave (
    input  rxd, rd_ready, clr_err,
    output rd_data, rd_valid, frame_err, overrun, parity_err
  );

endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous FIFO, power-of-two depth, async active-high reset.
//   push/din   - write request and data; accepted when not full, or when
//                full and a pop happens on the same edge
//   pop        - read request; ignored when empty
//   full/empty - occupancy status
//   head       - oldest entry, forced to 0 while empty
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;
  logic [AW:0]             count;
  logic                    wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign head  = empty ? '0 : mem[rptr];

  // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined)
// feeding an rx_fifo, with sticky frame/overrun/parity error flags.
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - uart_rx_fifo_if.slave (rxd in, FIFO read port and flags out)
// Parameters: CLK_FREQ_HZ, BAUD (CLK_FREQ_HZ/BAUD >= 4), FIFO_DEPTH (2..16,
// power of two).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_bad_cpb
      $error("uart_rx_fifo: CLK_FREQ_HZ/BAUD must be at least 4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two in 2..16");
    end
  endgenerate

  // ---------------- input synchronizer and edge detect ----------------
  logic [1:0] sync;
  logic       rx_s, rx_prev, armed, fall;
  logic [1:0] vld_pipe;

  assign rx_s = sync[1];

  // vld_pipe marks when sync[1] holds a real pin sample rather than the
  // reset value. armed only sets once a genuine high has been seen, so a line
  // already low at reset release cannot fake a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      rx_prev  <= 1'b1;
      armed    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[0], bus.rxd};
      rx_prev  <= rx_s;
      vld_pipe <= {vld_pipe[0], 1'b1};
      armed    <= armed | (vld_pipe[1] & rx_s);
    end
  end

  assign fall = armed && rx_prev && !rx_s;

  // ---------------- receive FSM ----------------
  rx_state_e         state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] sh;
  logic              samp, stop_hit, push, pop, full, empty;
  logic              frame_ev, ovr_ev;

  assign samp = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      case (state)
        IDLE: if (fall) begin
          state <= START;
          cnt   <= HALF;
        end
        START: if (samp) begin
          if (rx_s) state <= IDLE;   // glitch, not a start bit
          else begin
            state   <= DATA;
            cnt     <= FULL;
            bit_idx <= '0;
          end
        end else cnt <= cnt - CW'(1);
        DATA: if (samp) begin
          sh      <= {rx_s, sh[DATA_W-1:1]};   // LSB arrives first
          cnt     <= FULL;
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end else cnt <= cnt - CW'(1);
`ifdef UART_RX_PARITY_EN
        PARITY: if (samp) begin
          state <= STOP;
          cnt   <= FULL;
        end else cnt <= cnt - CW'(1);
`endif
        STOP: if (samp) state <= IDLE;
        else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // Push is decoded from the stop-sample cycle so the FIFO writes on that
  // same edge and rd_valid rises on the following cycle.
  assign stop_hit = (state == STOP) && samp;
  assign push     = stop_hit && rx_s;
  assign frame_ev = stop_hit && !rx_s;
  assign pop      = bus.rd_ready && !empty;
  assign ovr_ev   = push && full && !pop;

  rx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sh),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (bus.rd_data)
  );

  assign bus.rd_valid = !empty;

  // ---------------- sticky error flags ----------------
  // A new event takes priority over a coincident clr_err.
  logic frame_q, ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      frame_q <= frame_ev | (frame_q & ~bus.clr_err);
      ovr_q   <= ovr_ev   | (ovr_q   & ~bus.clr_err);
    end
  end

  assign bus.frame_err = frame_q;
  assign bus.overrun   = ovr_q;

`ifdef UART_RX_PARITY_EN
  // Even parity: the received parity bit must equal the XOR of the data bits.
  logic par_ev, par_q;
  assign par_ev = (state == PARITY) && samp && (rx_s != ^sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_ev | (par_q & ~bus.clr_err);
  end

  assign bus.parity_err = par_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 10 clocks/bit, FIFO_DEPTH=4. Received bytes are
// checked by a scoreboard queue; flags and timing by directed checks.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB = 10;
  // Edge (counted from the rxd fall) on which the stop bit is sampled:
  // 2 sync + 1 detect + 5 half-bit, then 8 data bits (+ parity) + stop at 10 each.
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 108;
`else
  localparam int STOP_EDGE = 98;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par);
    bus.rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    bus.rxd = par;
    tick(CPB);
`else
    if (par) bus.rxd = 1'b1;   // no parity slot in 8N1 frames
`endif
    bus.rxd = stop;
    tick(CPB);
    bus.rxd = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] d);
    send(d, 1'b1, ^d);
  endtask

  // One-cycle rd_ready pulse covering the stop-sample edge.
  task automatic pop_at_stop();
    repeat (STOP_EDGE-1) @(posedge clk);
    #1 bus.rd_ready = 1'b1;
    @(posedge clk);
    #1 bus.rd_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.rd_valid); i++) tick(1);
    bus.rd_ready = 1'b0;
    @(negedge clk);
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_valid"}, bus.rd_valid, 1'b0);
    chk({name, "_data0"}, bus.rd_data, 8'h00);
    tick(1);
  endtask

  // Monitor: every pop the DUT performs is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no data", bus.rd_data);
      end else begin
        chk("pop_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxd = 1'b1; bus.rd_ready = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.rd_valid, 1'b0);
    chk("rst_data", bus.rd_data, 8'h00);
    chk("rst_flags", {bus.frame_err, bus.overrun, bus.parity_err}, 3'b000);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;
    tick(5);

    // Single byte, push latency.
    exp_q.push_back(8'hA5);
    fork
      send_ok(8'hA5);
      begin
        repeat (STOP_EDGE-1) @(posedge clk);
        @(negedge clk);
        chk("lat_before", bus.rd_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_at", bus.rd_valid, 1'b1);
        chk("a5_head", bus.rd_data, 8'hA5);
      end
    join
    @(negedge clk);
    chk("a5_flags", {bus.frame_err, bus.overrun, bus.parity_err}, 3'b000);
    tick(1);
    drain("a5");

    // Short low glitch is a false start.
    bus.rxd = 1'b0; tick(3);
    bus.rxd = 1'b1; tick(20);
    @(negedge clk);
    chk("glitch_valid", bus.rd_valid, 1'b0);
    chk("glitch_flags", {bus.frame_err, bus.overrun, bus.parity_err}, 3'b000);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));
    tick(1);

    // Bad stop bit, then clear.
    send(8'h3C, 1'b0, ^8'h3C);
    tick(2);
    @(negedge clk);
    chk("fe_set", bus.frame_err, 1'b1);
    chk("fe_novalid", bus.rd_valid, 1'b0);
    tick(1);
    clr_pulse();
    @(negedge clk);
    chk("fe_clr", bus.frame_err, 1'b0);
    tick(1);

    // clr_err on the same edge as a new frame error: flag stays set.
    send(8'h3C, 1'b0, ^8'h3C);
    tick(2);
    fork
      send(8'h3C, 1'b0, ^8'h3C);
      begin
        repeat (STOP_EDGE-1) @(posedge clk);
        #1 bus.clr_err = 1'b1;
        @(posedge clk);
        #1 bus.clr_err = 1'b0;
      end
    join
    @(negedge clk);
    chk("fe_clr_race", bus.frame_err, 1'b1);
    tick(1);
    clr_pulse();

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_ok(8'(i));
    end
    tick(2);
    @(negedge clk);
    chk("ovr_set", bus.overrun, 1'b1);
    chk("ovr_head", bus.rd_data, 8'h01);
    tick(1);
    drain("ovr");
    clr_pulse();
    @(negedge clk);
    chk("ovr_clr", bus.overrun, 1'b0);
    tick(1);

    // Push and pop together while full: no overrun.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      send_ok(8'h11 + 8'(i));
    end
    exp_q.push_back(8'h15);
    fork
      send_ok(8'h15);
      pop_at_stop();
    join
    tick(2);
    @(negedge clk);
    chk("full_pp_ovr", bus.overrun, 1'b0);
    chk("full_pp_head", bus.rd_data, 8'h12);
    tick(1);
    drain("full_pp");

    // Push and pop together with one entry: head becomes the new byte.
    exp_q.push_back(8'h21);
    send_ok(8'h21);
    exp_q.push_back(8'h22);
    fork
      send_ok(8'h22);
      pop_at_stop();
    join
    @(negedge clk);
    chk("one_pp_valid", bus.rd_valid, 1'b1);
    chk("one_pp_head", bus.rd_data, 8'h22);
    tick(1);
    drain("one_pp");

    // Reset in the middle of a frame (during data bit 4).
    fork
      send_ok(8'hFF);
      begin
        tick(50);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    join
    tick(5);
    @(negedge clk);
    chk("rst_mid_valid", bus.rd_valid, 1'b0);
    tick(1);
    exp_q.push_back(8'h5A);
    send_ok(8'h5A);
    tick(2);
    drain("rst_mid");

    // Line already low at reset release: no start without a real edge.
    bus.rxd = 1'b0;
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(30);
    @(negedge clk);
    chk("low_rel_state", 32'(dut.state), 32'(IDLE));
    chk("low_rel_valid", bus.rd_valid, 1'b0);
    tick(1);
    bus.rxd = 1'b1; tick(5);
    exp_q.push_back(8'h66);
    send_ok(8'h66);
    tick(2);
    drain("low_rel");

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity expects a 1.
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b0);
    tick(2);
    @(negedge clk);
    chk("par_bad", bus.parity_err, 1'b1);
    chk("par_bad_head", bus.rd_data, 8'h07);
    tick(1);
    drain("par_bad");
    clr_pulse();
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b1);
    tick(2);
    @(negedge clk);
    chk("par_ok", bus.parity_err, 1'b0);
    tick(1);
    drain("par_ok");
`else
    @(negedge clk);
    chk("par_tied", bus.parity_err, 1'b0);
`endif

    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
